// File: rtl/inagu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inagu_ctrl_pkg
// Brief    : Shared constants and state encoding for the MVU input AGU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package inagu_ctrl_pkg;

    localparam int unsigned c_bprec_default = 6;
    localparam int unsigned c_bcnt_default  = 16;
    localparam int unsigned c_latency_max   = 7;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_clr   = 3'd1;
    localparam state_t c_st_run   = 3'd2;
    localparam state_t c_st_drain = 3'd3;
    localparam state_t c_st_done  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/inagu_ctrl_tag_delay.sv
`default_nettype none
// ============================================================================
// Module   : tag_delay
// Brief    : DEPTH-stage shift register for {first,last} step tags.
// Revision : 1.0 - initial release
// ============================================================================
module tag_delay #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_tag,
    output logic [1:0] o_tag,
    output logic       o_drained
);

    logic [DEPTH-1:0][1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_tag = r_sr[DEPTH-1];

    // Drained means no tag remains behind the output stage, so the pipe is
    // empty once the current output has been consumed.
    if (DEPTH == 1) begin : g_single
        assign o_drained = 1'b1;
    end else begin : g_multi
        assign o_drained = (r_sr[DEPTH-2:0] == '0);
    end

endmodule
`default_nettype wire

// File: rtl/inagu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inagu_ctrl
// Brief    : Job sequencer driving the MVU input/weight AGU and zig-zag unit.
// Revision : 1.0 - initial release
// ============================================================================
module inagu_ctrl
    import inagu_ctrl_pkg::*;
#(
    parameter int unsigned BPREC   = c_bprec_default,
    parameter int unsigned BCNT    = c_bcnt_default,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BPREC-1:0] cfg_iprecision,
    input  logic [BPREC-1:0] cfg_wprecision,
    input  logic [BCNT-1:0]  cfg_nvec,
    input  logic             stall,
    output logic [BPREC-1:0] iprecision,
    output logic [BPREC-1:0] wprecision,
    output logic             agu_en,
    output logic             zz_clr,
    output logic             zz_step,
    output logic             acc_clr,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned c_pw  = 2 * BPREC;
    localparam int unsigned c_lat = (LATENCY < 1) ? 1 :
                                    ((LATENCY > c_latency_max) ? c_latency_max : LATENCY);

    state_t           r_state;
    state_t           w_state_next;
    logic [BPREC-1:0] r_ip;
    logic [BPREC-1:0] r_wp;
    logic [BCNT-1:0]  r_nvec;
    logic [BCNT-1:0]  r_vcnt;
    logic [c_pw-1:0]  r_plen;
    logic [c_pw-1:0]  r_pcnt;
    logic             r_err;
    logic             w_cfg_ok;
    logic             w_accept;
    logic             w_step;
    logic             w_plast;
    logic             w_vlast;
    logic             w_drained;
    logic [1:0]       w_tag_in;
    logic [1:0]       w_tag_out;

    assign w_cfg_ok = (cfg_iprecision != '0) && (cfg_wprecision != '0) && (cfg_nvec != '0);
    assign w_accept = (r_state == c_st_idle) && start && w_cfg_ok;
    assign w_step   = (r_state == c_st_run) && !stall;
    assign w_plast  = (r_pcnt == r_plen - c_pw'(1));
    assign w_vlast  = (r_vcnt == r_nvec - BCNT'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_next = c_st_clr;
            c_st_clr:   w_state_next = c_st_run;
            c_st_run:   if (w_step && w_plast && w_vlast) w_state_next = c_st_drain;
            c_st_drain: if (w_drained) w_state_next = c_st_done;
            c_st_done:  w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        agu_en  = w_step;
        zz_step = w_step;
        zz_clr  = (r_state == c_st_clr);
        done    = (r_state == c_st_done);
        busy    = (r_state != c_st_idle);
    end

    // Config is captured only on an accepted start so port changes mid-job are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ip   <= '0;
            r_wp   <= '0;
            r_nvec <= '0;
            r_plen <= '0;
        end else if (w_accept) begin
            r_ip   <= cfg_iprecision;
            r_wp   <= cfg_wprecision;
            r_nvec <= cfg_nvec;
            r_plen <= c_pw'(cfg_iprecision) * c_pw'(cfg_wprecision);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_vcnt <= '0;
        end else if (r_state == c_st_clr) begin
            r_pcnt <= '0;
            r_vcnt <= '0;
        end else if (w_step) begin
            if (w_plast) begin
                r_pcnt <= '0;
                r_vcnt <= r_vcnt + BCNT'(1);
            end else begin
                r_pcnt <= r_pcnt + c_pw'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == c_st_idle) && start && !w_cfg_ok;
        end
    end

    // Stalled cycles push an all-zero bubble so tags stay aligned with memory data.
    assign w_tag_in = w_step ? {(r_pcnt == '0), w_plast} : 2'b00;

    tag_delay #(
        .DEPTH     (c_lat)
    ) u_tag_delay (
        .clk       (clk),
        .rst       (rst),
        .i_tag     (w_tag_in),
        .o_tag     (w_tag_out),
        .o_drained (w_drained)
    );

    assign acc_clr    = w_tag_out[1];
    assign out_valid  = w_tag_out[0];
    assign err        = r_err;
    assign iprecision = r_ip;
    assign wprecision = r_wp;

endmodule
`default_nettype wire

// File: tb/tb_inagu_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_inagu_ctrl
// Brief    : Directed bench for inagu_ctrl using a cycle-stamped event scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inagu_ctrl;

    localparam int BPREC   = 6;
    localparam int BCNT    = 16;
    localparam int LATENCY = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic [BPREC-1:0] cfg_iprecision = '0;
    logic [BPREC-1:0] cfg_wprecision = '0;
    logic [BCNT-1:0]  cfg_nvec = '0;
    logic [BPREC-1:0] iprecision;
    logic [BPREC-1:0] wprecision;
    logic             agu_en, zz_clr, zz_step, acc_clr, out_valid, busy, done, err;

    inagu_ctrl #(
        .BPREC          (BPREC),
        .BCNT           (BCNT),
        .LATENCY        (LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_iprecision (cfg_iprecision),
        .cfg_wprecision (cfg_wprecision),
        .cfg_nvec       (cfg_nvec),
        .stall          (stall),
        .iprecision     (iprecision),
        .wprecision     (wprecision),
        .agu_en         (agu_en),
        .zz_clr         (zz_clr),
        .zz_step        (zz_step),
        .acc_clr        (acc_clr),
        .out_valid      (out_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_step, n_busy, n_both, n_zclr;

    // Expected cycle stamps per event kind:
    // 0 zz_step, 1 agu_en, 2 zz_clr, 3 acc_clr, 4 out_valid, 5 done, 6 err
    int q0[$], q1[$], q2[$], q3[$], q4[$], q5[$], q6[$];
    int busy_lo[$], busy_hi[$];
    bit stall_plan [0:4095];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic int peek(input int k);
        int r = -1;
        case (k)
            0: if (q0.size() > 0) r = q0[0];
            1: if (q1.size() > 0) r = q1[0];
            2: if (q2.size() > 0) r = q2[0];
            3: if (q3.size() > 0) r = q3[0];
            4: if (q4.size() > 0) r = q4[0];
            5: if (q5.size() > 0) r = q5[0];
            default: if (q6.size() > 0) r = q6[0];
        endcase
        return r;
    endfunction

    task automatic pop(input int k);
        case (k)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            3: void'(q3.pop_front());
            4: void'(q4.pop_front());
            5: void'(q5.pop_front());
            default: void'(q6.pop_front());
        endcase
    endtask

    task automatic push(input int k, input int c);
        case (k)
            0: q0.push_back(c);
            1: q1.push_back(c);
            2: q2.push_back(c);
            3: q3.push_back(c);
            4: q4.push_back(c);
            5: q5.push_back(c);
            default: q6.push_back(c);
        endcase
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        q4.delete(); q5.delete(); q6.delete();
        busy_lo.delete(); busy_hi.delete();
    endtask

    // An asserted output must match the head stamp; a head stamp reached with
    // the output low is a missed event.
    task automatic ev(input int k, input logic v, input string nm);
        int e = peek(k);
        if ((v === 1'b1) || (e == cyc)) begin
            chk(nm, (v === 1'b1) ? cyc : -1, e);
            if (e == cyc) pop(k);
        end
    endtask

    task automatic run_cycle(input logic st);
        int eb;
        @(posedge clk);
        #1;
        cyc++;
        start = st;
        stall = (cyc < 4096) ? stall_plan[cyc] : 1'b0;
        #1;
        ev(0, zz_step,   "zz_step");
        ev(1, agu_en,    "agu_en");
        ev(2, zz_clr,    "zz_clr");
        ev(3, acc_clr,   "acc_clr");
        ev(4, out_valid, "out_valid");
        ev(5, done,      "done");
        ev(6, err,       "err");
        eb = 0;
        foreach (busy_lo[i]) if (cyc >= busy_lo[i] && cyc <= busy_hi[i]) eb = 1;
        chk("busy", (busy === 1'b1) ? 1 : 0, eb);
        if (zz_step === 1'b1) n_step++;
        if (busy === 1'b1) n_busy++;
        if (acc_clr === 1'b1 && out_valid === 1'b1) n_both++;
        if (zz_clr === 1'b1) n_zclr++;
    endtask

    // Spec timeline: start driven in cycle s -> zz_clr s+1, steps from s+2
    // skipping stalled cycles, tags LATENCY later, done LATENCY+1 after last step.
    task automatic plan(input int s, input int ip, input int wp, input int nv, output int d);
        int p    = ip * wp;
        int t    = s + 2;
        int last = s + 1;
        push(2, s + 1);
        for (int k = 0; k < p * nv; k++) begin
            while (stall_plan[t]) t++;
            push(0, t);
            push(1, t);
            if (k % p == 0)     push(3, t + LATENCY);
            if (k % p == p - 1) push(4, t + LATENCY);
            last = t;
            t++;
        end
        d = last + LATENCY + 1;
        push(5, d);
        busy_lo.push_back(s + 1);
        busy_hi.push_back(d);
    endtask

    task automatic go(input int ip, input int wp, input int nv, output int d);
        cfg_iprecision = BPREC'(ip);
        cfg_wprecision = BPREC'(wp);
        cfg_nvec       = BCNT'(nv);
        run_cycle(1'b1);
        if (ip != 0 && wp != 0 && nv != 0) begin
            plan(cyc, ip, wp, nv, d);
        end else begin
            push(6, cyc + 1);
            d = cyc + 1;
        end
    endtask

    task automatic run_until(input int d);
        while (cyc < d + 1) run_cycle(1'b0);
    endtask

    task automatic reset_counts();
        n_step = 0; n_busy = 0; n_both = 0; n_zclr = 0;
    endtask

    initial begin
        int d, d2, s;
        int zero_tab [3][3];
        zero_tab = '{'{4, 0, 5}, '{0, 2, 2}, '{3, 3, 0}};
        reset_counts();

        // Reset state
        repeat (3) run_cycle(1'b0);
        chk("reset_outputs", int'({iprecision, wprecision, agu_en, zz_clr, zz_step,
                                   acc_clr, out_valid, busy, done, err}), 0);
        rst = 1'b0;
        repeat (2) run_cycle(1'b0);

        // Job 2x3x2, no stall
        reset_counts();
        go(2, 3, 2, d);
        run_cycle(1'b0);
        run_cycle(1'b0);
        chk("latched_ip", int'(iprecision), 2);
        chk("latched_wp", int'(wprecision), 3);
        run_until(d);
        chk("s1_steps", n_step, 12);
        chk("s1_busy_cycles", n_busy, 16);

        // P=1 job with a stall on CLR (no effect) and on the final step
        reset_counts();
        s = cyc + 1;
        stall_plan[s + 1] = 1'b1;
        stall_plan[s + 4] = 1'b1;
        stall_plan[s + 5] = 1'b1;
        go(1, 1, 3, d);
        run_until(d);
        chk("s2_steps", n_step, 3);
        chk("s2_clr_and_valid", n_both, 3);
        chk("s2_zz_clr_count", n_zclr, 1);
        chk("s2_busy_cycles", n_busy, 9);

        // 4-cycle stall at step 7, config ports changed mid-job
        reset_counts();
        s = cyc + 1;
        for (int i = 0; i < 4; i++) stall_plan[s + 9 + i] = 1'b1;
        go(2, 3, 2, d);
        run_cycle(1'b0);
        cfg_iprecision = 6'd7;
        cfg_wprecision = 6'd7;
        cfg_nvec       = 16'd9;
        run_until(d);
        chk("s3_steps", n_step, 12);
        chk("s3_busy_cycles", n_busy, 20);
        chk("s3_ip_immune", int'(iprecision), 2);
        chk("s3_wp_immune", int'(wprecision), 3);

        // Zero config fields -> err pulse, never busy
        reset_counts();
        for (int i = 0; i < 3; i++) begin
            go(zero_tab[i][0], zero_tab[i][1], zero_tab[i][2], d);
            run_cycle(1'b0);
            run_cycle(1'b0);
        end
        chk("s4_err_busy", n_busy, 0);

        // start during a running job is ignored
        reset_counts();
        go(2, 3, 2, d);
        repeat (3) run_cycle(1'b0);
        cfg_iprecision = 6'd1;
        cfg_wprecision = 6'd1;
        cfg_nvec       = 16'd1;
        run_cycle(1'b1);
        run_until(d);
        chk("s4_steps_ignored_start", n_step, 12);
        chk("s4_zz_clr_count", n_zclr, 1);

        // Asynchronous reset at step 5
        reset_counts();
        go(2, 3, 2, d);
        s = cyc;
        while (cyc < s + 7) run_cycle(1'b0);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({iprecision, wprecision, agu_en, zz_clr, zz_step,
                                         acc_clr, out_valid, busy, done, err}), 0);
        chk("s5_aborted_steps", n_step, 6);
        clear_all();
        run_cycle(1'b0);
        run_cycle(1'b0);
        rst = 1'b0;
        repeat (4) run_cycle(1'b0);
        reset_counts();
        go(2, 3, 2, d);
        run_until(d);
        chk("s5_restart_steps", n_step, 12);

        // Back-to-back jobs with start held high
        reset_counts();
        go(1, 2, 1, d);
        plan(d + 1, 1, 2, 1, d2);
        while (cyc < d2) run_cycle(1'b1);
        run_until(d2);
        repeat (4) run_cycle(1'b0);
        chk("s6_zz_clr_count", n_zclr, 2);
        chk("s6_steps", n_step, 4);

        chk("pending_events", q0.size() + q1.size() + q2.size() + q3.size() +
                              q4.size() + q5.size() + q6.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
